// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between the core port and the debug port,
// with one access in flight and a bus timeout. Define MEM_ARB_RR_EN for a round-robin tie-break.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              c_done_q, c_done_d, d_done_q, d_done_d;
    logic              c_err_q, c_err_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic              grant_dbg;
    logic              fin_err;
    logic [DATA_W-1:0] fin_data;

`ifdef MEM_ARB_RR_EN
    // rr_ptr_q holds the port granted last; the other port wins a tie.
    logic rr_ptr_q;

    assign grant_dbg = d_req && (!c_req || !rr_ptr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b1;
        end else if (state_q == ST_IDLE && (c_req || d_req)) begin
            rr_ptr_q <= grant_dbg;
        end
    end
`else
    assign grant_dbg = d_req && !c_req;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        c_done_d  = 1'b0;
        d_done_d  = 1'b0;
        c_err_d   = c_err_q;
        d_err_d   = d_err_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        fin_err   = 1'b0;
        fin_data  = '0;

        case (state_q)
            ST_IDLE: begin
                if (c_req || d_req) begin
                    state_d   = ST_BUSY;
                    owner_d   = grant_dbg;
                    cnt_d     = '0;
                    m_req_d   = 1'b1;
                    m_we_d    = grant_dbg ? d_we    : c_we;
                    m_addr_d  = grant_dbg ? d_addr  : c_addr;
                    m_wdata_d = grant_dbg ? d_wdata : c_wdata;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // An ack on the terminal-count cycle still wins over the timeout.
                if (m_ack || cnt_q == TERM_CNT) begin
                    state_d  = ST_DONE;
                    m_req_d  = 1'b0;
                    fin_err  = !m_ack;
                    fin_data = (m_ack && !m_we_q) ? m_rdata : '0;
                    if (owner_q) begin
                        d_done_d  = 1'b1;
                        d_err_d   = fin_err;
                        d_rdata_d = fin_data;
                    end else begin
                        c_done_d  = 1'b1;
                        c_err_d   = fin_err;
                        c_rdata_d = fin_data;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            c_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_done_q  <= c_done_d;
            d_done_q  <= d_done_d;
            c_err_q   <= c_err_d;
            d_err_q   <= d_err_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign c_done  = c_done_q;
    assign c_err   = c_err_q;
    assign c_rdata = c_rdata_q;
    assign d_done  = d_done_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory responder model plus a completion scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              c_req = 1'b0, c_we = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic              c_done, c_err;
    logic [DATA_W-1:0] c_rdata;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_done, d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              port;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int              ack_delay = 0;
    logic            ack_en = 1'b0;
    logic [DATA_W-1:0] rd_val = '0;
    int              wait_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks after ack_delay wait cycles of m_req, never if ack_en is low.
    always @(negedge clk) begin
        if (m_req) begin
            m_ack   = ack_en && (wait_cnt == ack_delay);
            m_rdata = m_ack ? rd_val : 32'hFFFF_FFFF;
            wait_cnt++;
        end else begin
            m_ack    = 1'b0;
            m_rdata  = 32'hFFFF_FFFF;
            wait_cnt = 0;
        end
    end

    // Completion monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (c_done || d_done) begin
            if (c_done && d_done) begin
                check("both_done", 1, 0);
            end else if (sb_q.size() == 0) begin
                check("unexpected_done", {d_done, c_done}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_port", d_done, mon_e.port);
                check("err", d_done ? d_err : c_err, mon_e.err);
                check("rdata", d_done ? d_rdata : c_rdata, mon_e.rdata);
            end
        end
    end

    task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits, input logic ack_on,
                             input logic [31:0] rdv, input logic exp_err, input int exp_lat);
        int   start;
        int   nbusy;
        bit   seen;
        exp_t e;
        @(negedge clk);
        ack_delay = waits;
        ack_en    = ack_on;
        rd_val    = rdv;
        e.port    = port;
        e.err     = exp_err;
        e.rdata   = (exp_err || we) ? 32'h0 : rdv;
        sb_q.push_back(e);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        start = cyc;
        nbusy = 0;
        seen  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (m_req) begin
                nbusy++;
                check("m_hold", {m_we, m_addr, m_wdata}, {we, addr, wdata});
                if (port) begin
                    d_we = ~we; d_addr = ~addr; d_wdata = ~wdata;
                end else begin
                    c_we = ~we; c_addr = ~addr; c_wdata = ~wdata;
                end
            end
            if (port ? d_done : c_done) begin
                seen = 1;
                check("latency", cyc - start, exp_lat);
                check("busy_cycles", nbusy, exp_lat - 1);
                check("m_req_in_done", m_req, 0);
                check("busy_in_done", busy, 1);
                if (port) d_req = 1'b0; else c_req = 1'b0;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            c_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    task automatic do_ties();
        logic exp_win [4];
        exp_t e;
        bit   seen;
`ifdef MEM_ARB_RR_EN
        exp_win = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        @(negedge clk);
        ack_delay = 0;
        ack_en    = 1'b1;
        rd_val    = 32'h5A5A_0001;
        c_we = 1'b0; c_addr = 32'h0000_0400;
        d_we = 1'b0; d_addr = 32'h0000_0800;
        for (int k = 0; k < 4; k++) begin
            e.port  = exp_win[k];
            e.err   = 1'b0;
            e.rdata = 32'h5A5A_0001;
            sb_q.push_back(e);
        end
        c_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (c_done || d_done) begin
                    seen = 1;
                    check("tie_grant", d_done, exp_win[k]);
                end
            end
            if (!seen) check("tie_timeout", 0, 1);
        end
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_dones", {c_done, d_done}, 0);
        check("rst_errs", {c_err, d_err}, 0);
        check("rst_rdata", {c_rdata, d_rdata}, 0);
        rst = 1'b0;

        do_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        do_access(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4, 1'b1, 32'hAAAA_5555, 1'b0, 6);
        check("c_rdata_hold", c_rdata, 32'hDEAD_BEEF);
        check("c_err_hold", c_err, 0);

        do_ties();

        do_access(1'b0, 1'b0, 32'h0000_0080, 32'h0, 0, 1'b0, 32'h1111_2222, 1'b1, TIMEOUT + 1);
        do_access(1'b0, 1'b0, 32'h0000_00C0, 32'h0, TIMEOUT - 1, 1'b1, 32'hCAFE_F00D, 1'b0, TIMEOUT + 1);
        do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 2, 1'b1, 32'h0F0F_1234, 1'b0, 4);

        @(negedge clk);
        ack_en = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0200;
        repeat (3) @(negedge clk);
        check("pre_rst_m_req", m_req, 1);
        rst = 1'b1;
        #1;
        check("async_rst_m_req", m_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rdata", c_rdata, 0);
        c_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        do_access(1'b0, 1'b1, 32'h0000_0300, 32'h7777_8888, 1, 1'b1, 32'h9999_AAAA, 1'b0, 3);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
